vga_frame_scanout: RTL and testbench



---
 rtl/vga_frame_scanout.sv | 126 ++++++++++++
 tb/tb_vga_frame_scanout.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scanout.sv
// 320x240x12 frame buffer with a free-running write port, scanned out as 640x480@60 VGA
// with 2x2 pixel replication and a one-clock pulse on entry to vertical blanking.
module vga_frame_scanout #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [11:0] color,
    input  logic        writeEn,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk,
    output logic        frame_start
);

    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOT);
    localparam int VW       = $clog2(V_TOT);
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int AW       = $clog2(FB_DEPTH);

    logic          pix_en_q, pix_en_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          vis_q, vis_d;
    logic          frame_start_q, frame_start_d;

    logic          h_wrap, v_wrap;
    logic          hs_raw, vs_raw, vis_raw;
    logic          wr_ok;
    logic [AW-1:0] raddr, waddr;
    logic [11:0]   rd_data_q;
    logic [11:0]   mem [FB_DEPTH];

    assign h_wrap  = (h_cnt_q == HW'(H_TOT - 1));
    assign v_wrap  = (v_cnt_q == VW'(V_TOT - 1));
    assign hs_raw  = !((h_cnt_q >= HW'(H_VIS + H_FP)) && (h_cnt_q < HW'(H_VIS + H_FP + H_SYNC)));
    assign vs_raw  = !((v_cnt_q >= VW'(V_VIS + V_FP)) && (v_cnt_q < VW'(V_VIS + V_FP + V_SYNC)));
    assign vis_raw = (h_cnt_q < HW'(H_VIS)) && (v_cnt_q < VW'(V_VIS));

    // Row*FB_W + col; for FB_W=320 this folds to (r<<8)+(r<<6)+c. Held at 0 in blanking
    // so the address never leaves the buffer.
    assign raddr = vis_raw ? AW'(32'(v_cnt_q >> 1) * FB_W + 32'(h_cnt_q >> 1)) : '0;
    assign waddr = AW'(32'(y) * FB_W + 32'(x));
    assign wr_ok = writeEn && (32'(x) < FB_W) && (32'(y) < FB_H);

    always_comb begin
        pix_en_d      = ~pix_en_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        vis_d         = vis_q;
        frame_start_d = 1'b0;
        if (pix_en_q) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
            end
            // Sync and visibility are delayed one tick to line up with the RAM read.
            hs_d          = hs_raw;
            vs_d          = vs_raw;
            vis_d         = vis_raw;
            frame_start_d = h_wrap && (v_cnt_q == VW'(V_VIS - 1));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            vis_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            vis_q         <= vis_d;
            frame_start_q <= frame_start_d;
        end
    end

    // NOTE: the frame buffer and its read register carry no reset so they map onto block RAM;
    // the non-blocking write also gives read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= color;
        end
        if (pix_en_q) begin
            rd_data_q <= mem[raddr];
        end
    end

    assign {vga_r, vga_g, vga_b} = vis_q ? rd_data_q : 12'h000;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = vis_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = pix_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout on a scaled-down raster (16x12 buffer, 48x31 timing) so whole
// frames fit in a short run; a per-clock positional model checks every output.
module tb_vga_frame_scanout;

    localparam int FB_W   = 16;
    localparam int FB_H   = 12;
    localparam int H_VIS  = 32;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 6;
    localparam int H_BP   = 6;
    localparam int V_VIS  = 24;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int F      = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [8:0]  x = '0;
    logic [7:0]  y = '0;
    logic [11:0] color = '0;
    logic        writeEn = 1'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

    vga_frame_scanout #(
        .FB_W(FB_W), .FB_H(FB_H),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .color(color), .writeEn(writeEn),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;

    logic [11:0] img [FB_W*FB_H];
    logic [11:0] screen [H_VIS*V_VIS];
    logic        e_hs, e_vs, e_blank, e_fs;
    logic [11:0] e_rgb;
    bit          last_tick;
    bit          capture = 0;
    int          cur_h, cur_v;
    int          vs_low = 0;
    int          fs_k[$];

    typedef struct {
        logic        we;
        int          wx, wy;
        logic [11:0] wc;
        int          px, py;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    function automatic logic [11:0] bg(input int i);
        return 12'(i * 37 + 5);
    endfunction

    task automatic model_reset();
        k       = 0;
        e_hs    = 1'b1;
        e_vs    = 1'b1;
        e_blank = 1'b0;
        e_rgb   = 12'h000;
        e_fs    = 1'b0;
    endtask

    // One clk: drive at the negedge, model the posedge, compare at the next negedge.
    task automatic step(input logic we, input int wx, input int wy, input logic [11:0] wc);
        int t, p;
        writeEn = we;
        x       = 9'(wx);
        y       = 8'(wy);
        color   = wc;
        @(posedge clk);
        k++;
        last_tick = (k % 2 == 0);
        e_fs      = 1'b0;
        if (last_tick) begin
            t       = k / 2;
            p       = (t - 1) % F;
            cur_h   = p % H_TOT;
            cur_v   = p / H_TOT;
            e_blank = (cur_h < H_VIS) && (cur_v < V_VIS);
            e_hs    = !(cur_h >= H_VIS + H_FP && cur_h < H_VIS + H_FP + H_SYNC);
            e_vs    = !(cur_v >= V_VIS + V_FP && cur_v < V_VIS + V_FP + V_SYNC);
            e_rgb   = e_blank ? img[(cur_v / 2) * FB_W + cur_h / 2] : 12'h000;
            e_fs    = (cur_h == H_TOT - 1) && (cur_v == V_VIS - 1);
        end
        if (we && int'(x) < FB_W && int'(y) < FB_H) img[int'(y) * FB_W + int'(x)] = wc;
        @(negedge clk);
        check("scan {rgb,hs,vs,blank_n,sync_n,vga_clk,frame_start}",
              {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start},
              {e_rgb, e_hs, e_vs, e_blank, 1'b0, 1'(k % 2), e_fs});
        if (frame_start) fs_k.push_back(k);
        if (capture && last_tick && e_blank) screen[cur_v * H_VIS + cur_h] = {vga_r, vga_g, vga_b};
        if (capture && last_tick && !vga_vs) vs_low++;
    endtask

    // Idle until the next edge is the pixel tick that samples raster position `target`.
    task automatic wait_pos(input int target);
        int budget = 4 * F;
        while (!(((k + 1) % 2 == 0) && ((((k + 1) / 2) - 1) % F == target))) begin
            if (budget == 0) begin
                timeout("wait_pos");
                return;
            end
            budget--;
            step(1'b0, 0, 0, 12'h000);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " hs"}, vga_hs, 1);
        check({tag, " vs"}, vga_vs, 1);
        check({tag, " blank_n"}, vga_blank_n, 0);
        check({tag, " rgb"}, {vga_r, vga_g, vga_b}, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " vga_clk"}, vga_clk, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, lo, bl;
        logic [11:0] old;

        #2 resetn = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();

        for (int i = 0; i < FB_W * FB_H; i++) step(1'b1, i % FB_W, i / FB_W, bg(i));

        vecs[0] = '{1'b1,   0,   0, 12'hF00,  0,  0, 12'hF00};
        vecs[1] = '{1'b0,   0,   0, 12'h000,  1,  1, 12'hF00};
        vecs[2] = '{1'b1,  15,  11, 12'h00F, 31, 23, 12'h00F};
        vecs[3] = '{1'b0,   0,   0, 12'h000, 30, 22, 12'h00F};
        vecs[4] = '{1'b0,   0,   0, 12'h000,  2,  0, bg(1)};
        vecs[5] = '{1'b0,   0,   0, 12'h000, 29, 23, bg(190)};
        vecs[6] = '{1'b1, 320,  10, 12'hFFF,  0,  2, bg(16)};
        vecs[7] = '{1'b1,  16,   3, 12'hFFF,  0,  8, bg(64)};
        vecs[8] = '{1'b1,   5, 240, 12'hFFF, 10,  0, bg(5)};
        vecs[9] = '{1'b0,   0,   0, 12'h000, 11,  1, bg(5)};
        foreach (vecs[i]) if (vecs[i].we) step(1'b1, vecs[i].wx, vecs[i].wy, vecs[i].wc);

        wait_pos(0);
        capture = 1;
        vs_low  = 0;
        repeat (2 * F) step(1'b0, 0, 0, 12'h000);
        capture = 0;
        foreach (vecs[i])
            check($sformatf("pixel(%0d,%0d)", vecs[i].px, vecs[i].py),
                  screen[vecs[i].py * H_VIS + vecs[i].px], vecs[i].exp_rgb);
        check("vs low ticks per frame", vs_low, V_SYNC * H_TOT);

        if (fs_k.size() >= 2) begin
            check("first frame_start cycle", fs_k[0], 2 * V_VIS * H_TOT);
            check("frame_start spacing", fs_k[1] - fs_k[0], 2 * F);
        end else begin
            timeout("frame_start pulses");
        end

        wait_pos(3 * H_TOT);
        first = -1;
        lo    = 0;
        bl    = 0;
        for (int i = 0; i < H_TOT; i++) begin
            step(1'b0, 0, 0, 12'h000);
            if (!vga_hs) begin
                if (first < 0) first = i;
                lo++;
            end
            if (vga_blank_n) bl++;
            step(1'b0, 0, 0, 12'h000);
        end
        check("hs fall ticks after line start", first + 1, H_VIS + H_FP + 1);
        check("hs low ticks", lo, H_SYNC);
        check("blank_n high ticks", bl, H_VIS);

        wait_pos(4 * H_TOT + 4);
        old = img[2 * FB_W + 2];
        step(1'b1, 2, 2, 12'h0F0);
        check("collision same frame", {vga_r, vga_g, vga_b}, old);
        wait_pos(4 * H_TOT + 4);
        step(1'b0, 0, 0, 12'h000);
        check("collision next frame", {vga_r, vga_g, vga_b}, 12'h0F0);

        repeat (2 * F)
            step(1'($urandom_range(0, 2) == 0), $urandom_range(0, FB_W + 2),
                 $urandom_range(0, FB_H + 2), 12'($urandom));

        wait_pos(10 * H_TOT + 20);
        step(1'b0, 0, 0, 12'h000);
        step(1'b0, 0, 0, 12'h000);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("mid-frame reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        step(1'b0, 0, 0, 12'h000);
        step(1'b0, 0, 0, 12'h000);
        check("restart blank_n", vga_blank_n, 1);
        check("restart top-left pixel", {vga_r, vga_g, vga_b}, img[0]);
        repeat (2 * F) step(1'b0, 0, 0, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
